// File: rtl/addsub_rr_sched.sv
// Two-requester round-robin front end sharing one 4-bit add/sub slice.
// Each operation runs nibble-serially with a registered carry chain.
module addsub_rr_sched #(
  parameter int unsigned NIB = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [4*NIB-1:0]  req0_a,
  input  logic [4*NIB-1:0]  req0_b,
  input  logic              req0_m,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [4*NIB-1:0]  req1_a,
  input  logic [4*NIB-1:0]  req1_b,
  input  logic              req1_m,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [4*NIB-1:0]  rsp_sum,
  output logic              rsp_c,
  output logic              rsp_ovf,
  output logic              rsp_id
);

  localparam int unsigned W  = 4 * NIB;
  localparam int unsigned SW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [SW-1:0] LastStep = SW'(NIB - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic          prio_q, prio_d;
  logic [SW-1:0] step_q, step_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic          m_q, m_d, id_q, id_d, ovf_q, ovf_d;

  logic       any_valid, grant;
  logic [3:0] a_nib, b_nib, slice_sum;
  logic [4:0] slice_full;
  logic       cin, cout, c_msb;

  assign any_valid = req0_valid | req1_valid;
  // Contention goes to prio_q; a lone requester always wins.
  assign grant     = (req0_valid & req1_valid) ? prio_q : req1_valid;

  assign req0_ready = rst_n && (state_q == StIdle) && any_valid && !grant;
  assign req1_ready = rst_n && (state_q == StIdle) && any_valid && grant;

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < int'(NIB); i++) begin
      if (step_q == SW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4] ^ {4{m_q}};
      end
    end
  end

  assign cin        = (step_q == '0) ? m_q : carry_q;
  assign slice_full = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, cin};
  assign slice_sum  = slice_full[3:0];
  assign cout       = slice_full[4];
  // Carry into the slice MSB recovered from the MSB sum bit and its operands.
  assign c_msb      = a_nib[3] ^ b_nib[3] ^ slice_sum[3];

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    step_d  = step_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    id_d    = id_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          a_d     = grant ? req1_a : req0_a;
          b_d     = grant ? req1_b : req0_b;
          m_d     = grant ? req1_m : req0_m;
          id_d    = grant;
          res_d   = '0;
          step_d  = '0;
          prio_d  = ~grant;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int i = 0; i < int'(NIB); i++) begin
          if (step_q == SW'(i)) res_d[4*i +: 4] = slice_sum;
        end
        carry_d = cout;
        if (step_q == LastStep) begin
          ovf_d   = c_msb ^ cout;
          state_d = StDone;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      StDone: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      prio_q  <= 1'b0;
      step_q  <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= 1'b0;
      id_q    <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      step_q  <= step_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      id_q    <= id_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rsp_valid = rst_n && (state_q == StDone);
  assign rsp_sum   = res_q;
  assign rsp_c     = carry_q;
  assign rsp_ovf   = ovf_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_addsub_rr_sched.sv
// Directed bench for addsub_rr_sched with a response scoreboard fed at each accept.
module tb_addsub_rr_sched;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_m;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_m;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_c, rsp_ovf, rsp_id;
  logic [W-1:0] rsp_sum;

  addsub_rr_sched #(.NIB(NIB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_m     (req0_m),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_m     (req1_m),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_c      (rsp_c),
    .rsp_ovf    (rsp_ovf),
    .rsp_id     (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         id;
    logic [W-1:0] sum;
    logic         c;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t sb[$];
  logic acc_ids[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  logic prev_rv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: one full-width ripple add of A + (B ^ m) + m.
  function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic m, input int acc);
    exp_t         e;
    logic [W-1:0] bx;
    logic [W:0]   full;
    bx    = b ^ {W{m}};
    full  = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, m};
    e.id  = id;
    e.sum = full[W-1:0];
    e.c   = full[W];
    e.ovf = (a[W-1] == bx[W-1]) && (full[W-1] != a[W-1]);
    e.acc = acc;
    return e;
  endfunction

  // Sample 1 time unit after a negedge, score the cycle, then advance to the next negedge.
  task automatic step();
    exp_t e;
    #1;
    cyc++;
    if (!rst_n) begin
      chk("reset_quiet", 32'({req0_ready, req1_ready, rsp_valid}), 32'(0));
      prev_rv = 1'b0;
    end else begin
      chk("one_ready", 32'(req0_ready & req1_ready), 32'(0));
      if (rsp_valid) chk("ready_while_busy", 32'(req0_ready | req1_ready), 32'(0));
      if (rsp_valid && !prev_rv) begin
        if (sb.size() == 0) chk("rsp_pending", 32'(sb.size() != 0), 32'(1));
        // Sample k precedes accept edge E0; sample k+1+j follows edge E0+j.
        else chk("latency", 32'(cyc - sb[0].acc), 32'(NIB + 1));
      end
      if (rsp_valid && rsp_ready && sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
        chk("rsp_c",   32'(rsp_c),   32'(e.c));
        chk("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
        chk("rsp_id",  32'(rsp_id),  32'(e.id));
      end
      if (req0_ready) begin
        sb.push_back(model(1'b0, req0_a, req0_b, req0_m, cyc));
        acc_ids.push_back(1'b0);
      end
      if (req1_ready) begin
        sb.push_back(model(1'b1, req1_a, req1_b, req1_m, cyc));
        acc_ids.push_back(1'b1);
      end
      prev_rv = rsp_valid;
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic m);
    int n;
    if (id) begin
      req1_a = a; req1_b = b; req1_m = m; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_m = m; req0_valid = 1'b1;
    end
    n = acc_ids.size();
    for (int i = 0; i < 20 && acc_ids.size() == n; i++) step();
    chk("accepted", 32'(acc_ids.size()), 32'(n + 1));
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) step();
    chk("drained", 32'(sb.size()), 32'(0));
  endtask

  task automatic do_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic m);
    issue(id, a, b, m);
    drain();
  endtask

  logic [W-1:0] f_sum;
  logic         f_c, f_ovf, f_id;

  initial begin
    rst_n      = 1'b0;
    rsp_ready  = 1'b1;
    req0_valid = 1'b1; req0_a = 16'h1111; req0_b = 16'h2222; req0_m = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h5000; req1_b = 16'h1234; req1_m = 1'b1;
    @(negedge clk);
    repeat (3) step();
    chk("rst_sum", 32'(rsp_sum), 32'(0));
    chk("rst_flags", 32'({rsp_c, rsp_ovf, rsp_id}), 32'(0));

    // Contention from reset release: strict alternation.
    rst_n = 1'b1;
    for (int i = 0; i < 100 && acc_ids.size() < 4; i++) step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("grant_count", 32'(acc_ids.size()), 32'(4));
    for (int i = 0; i < 4 && i < acc_ids.size(); i++) chk("grant_order", 32'(acc_ids[i]), 32'(i % 2));
    drain();

    // Arithmetic cases.
    do_op(1'b0, 16'h1234, 16'h0FFF, 1'b0);
    do_op(1'b1, 16'h0008, 16'h0002, 1'b1);
    do_op(1'b0, 16'h0002, 16'h0008, 1'b1);
    do_op(1'b1, 16'hFFFF, 16'h0001, 1'b0);
    do_op(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    do_op(1'b1, 16'h8000, 16'h0001, 1'b1);
    do_op(1'b0, 16'hA5C3, 16'h5A3C, 1'b1);

    // Backpressure in DONE with a competing request pending.
    rsp_ready = 1'b0;
    issue(1'b0, 16'h00F0, 16'h0F10, 1'b0);
    req1_a = 16'h4321; req1_b = 16'h1111; req1_m = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 20 && !rsp_valid; i++) step();
    chk("bp_valid", 32'(rsp_valid), 32'(1));
    f_sum = rsp_sum; f_c = rsp_c; f_ovf = rsp_ovf; f_id = rsp_id;
    repeat (5) begin
      step();
      chk("bp_hold_valid", 32'(rsp_valid), 32'(1));
      chk("bp_hold_fields", 32'({rsp_sum, rsp_c, rsp_ovf, rsp_id}), 32'({f_sum, f_c, f_ovf, f_id}));
      chk("bp_no_ready", 32'({req0_ready, req1_ready}), 32'(0));
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_released", 32'(rsp_valid), 32'(0));
    chk("bp_next_grant", 32'(req1_ready), 32'(1));
    step();
    req1_valid = 1'b0;
    drain();

    // Reset while in RUN step 2 aborts the operation.
    issue(1'b0, 16'h3333, 16'h4444, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    sb.delete();
    step();
    rst_n = 1'b1;
    chk("abort_idle", 32'(rsp_valid), 32'(0));
    repeat (NIB + 3) step();
    chk("abort_no_rsp", 32'(rsp_valid), 32'(0));
    // prio was 1 before the reset; both valid must now pick requester 0.
    req0_a = 16'h3333; req0_b = 16'h4444; req0_m = 1'b0; req0_valid = 1'b1;
    req1_a = 16'h0100; req1_b = 16'h0200; req1_m = 1'b1; req1_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("prio_after_reset", 32'(acc_ids[acc_ids.size()-1]), 32'(0));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
